// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array: skews accepted K-beats across lanes,
// then flushes 2N-2 zero beats. Optional activation offset enabled by FEEDER_INPUT_OFFSET_EN.
module systolic_feeder #(
   parameter int unsigned N            = 4,
   parameter int          INPUT_OFFSET = 128
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic           s_last,
   input  logic [N*8-1:0] s_act,
   input  logic [N*8-1:0] s_wgt,
   output logic [N*9-1:0] row_bus,
   output logic [N*8-1:0] col_bus,
   output logic           arr_valid,
   output logic           arr_clear,
   output logic           busy,
   output logic           done
);

   typedef enum logic [2:0] {StIdle, StClear, StStream, StFlush, StDone} state_e;

   localparam int unsigned CntW = $clog2(2 * N - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              arr_valid_q;
   logic              advance;
   logic              shift_zero;
   logic              clear_skew;

`ifdef FEEDER_INPUT_OFFSET_EN
   localparam logic signed [8:0] Offset9 = 9'(INPUT_OFFSET);
`else
   logic [31:0] unused_offset;
   assign unused_offset = 32'(INPUT_OFFSET);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         arr_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         arr_valid_q <= advance;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      advance    = 1'b0;
      shift_zero = 1'b0;
      clear_skew = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StClear;
         end
         StClear: begin
            clear_skew = 1'b1;
            state_d    = StStream;
         end
         StStream: begin
            if (s_valid) begin
               advance = 1'b1;
               if (s_last) begin
                  cnt_d   = CntW'(2 * N - 2);
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            // The final FLUSH cycle presents the last zero beat without advancing.
            if (cnt_q != '0) begin
               advance    = 1'b1;
               shift_zero = 1'b1;
               cnt_d      = cnt_q - CntW'(1);
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign s_ready   = (state_q == StStream);
   assign arr_clear = (state_q == StClear);
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign arr_valid = arr_valid_q;

   // Lane i holds an (i+1)-deep shift chain, so its output lags lane 0 by i advances.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic signed [8:0] row_sr_q [i+1];
      logic        [7:0] col_sr_q [i+1];
      logic signed [8:0] act_ext;
      logic signed [8:0] row_in;
      logic        [7:0] col_in;

      assign act_ext = {s_act[8*i+7], s_act[8*i +: 8]};
`ifdef FEEDER_INPUT_OFFSET_EN
      assign row_in  = shift_zero ? 9'sd0 : act_ext + Offset9;
`else
      assign row_in  = shift_zero ? 9'sd0 : act_ext;
`endif
      assign col_in  = shift_zero ? 8'd0 : s_wgt[8*i +: 8];

      always_ff @(posedge clk) begin
         if (!rst_n || clear_skew) begin
            for (int j = 0; j <= i; j++) begin
               row_sr_q[j] <= '0;
               col_sr_q[j] <= '0;
            end
         end else if (advance) begin
            row_sr_q[0] <= row_in;
            col_sr_q[0] <= col_in;
            for (int j = 1; j <= i; j++) begin
               row_sr_q[j] <= row_sr_q[j-1];
               col_sr_q[j] <= col_sr_q[j-1];
            end
         end
      end

      assign row_bus[9*i +: 9] = row_sr_q[i];
      assign col_bus[8*i +: 8] = col_sr_q[i];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Table-driven bench for systolic_feeder (N=4): full tiles, gaps, single-beat tile,
// reset abort during FLUSH and a follow-up tile.
module tb_systolic_feeder;

   localparam int N   = 4;
   localparam int OFS = 128;

   localparam logic [8:0] Z9 = 9'd0;
   localparam logic [7:0] Z8 = 8'd0;

   // {s_ready, arr_valid, arr_clear, busy, done}
   localparam logic [4:0] F_IDLE = 5'b00000;
   localparam logic [4:0] F_CLR  = 5'b00110;
   localparam logic [4:0] F_STR  = 5'b10010;
   localparam logic [4:0] F_STAV = 5'b11010;
   localparam logic [4:0] F_FLAV = 5'b01010;
   localparam logic [4:0] F_DONE = 5'b00011;

   typedef struct {
      logic [2:0]  ctl_in;   // {start, s_valid, s_last}
      logic [31:0] act;
      logic [31:0] wgt;
      logic [4:0]  flags;
      logic [35:0] row;
      logic [31:0] col;
   } vec_t;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           s_valid;
   logic           s_ready;
   logic           s_last;
   logic [N*8-1:0] s_act;
   logic [N*8-1:0] s_wgt;
   logic [N*9-1:0] row_bus;
   logic [N*8-1:0] col_bus;
   logic           arr_valid;
   logic           arr_clear;
   logic           busy;
   logic           done;

   int   n_chk;
   int   n_fail;
   int   step_id;
   vec_t vec_q[$];

   systolic_feeder #(
      .N            (N),
      .INPUT_OFFSET (OFS)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .s_act     (s_act),
      .s_wgt     (s_wgt),
      .row_bus   (row_bus),
      .col_bus   (col_bus),
      .arr_valid (arr_valid),
      .arr_clear (arr_clear),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] rv(input int a);
`ifdef FEEDER_INPUT_OFFSET_EN
      return 9'(a + OFS);
`else
      return 9'(a);
`endif
   endfunction

   function automatic logic [35:0] r4(input logic [8:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [31:0] c4(input logic [7:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic add(input logic [2:0] ci, input logic [31:0] a, input logic [31:0] w,
                      input logic [4:0] f, input logic [35:0] r, input logic [31:0] c);
      vec_t v;
      v.ctl_in = ci;
      v.act    = a;
      v.wgt    = w;
      v.flags  = f;
      v.row    = r;
      v.col    = c;
      vec_q.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", nm, step_id, got, exp);
      end
   endtask

   task automatic drive(input logic st, input logic sv, input logic sl,
                        input logic [31:0] a, input logic [31:0] w);
      start   = st;
      s_valid = sv;
      s_last  = sl;
      s_act   = a;
      s_wgt   = w;
   endtask

   logic [4:0] flags_now;
   assign flags_now = {s_ready, arr_valid, arr_clear, busy, done};

   initial begin
      logic [31:0] a1, w1, aa, wa, ab, wb, ad, wd;
      int av_cnt, clr_cnt;
      bit saw_done;

      n_chk   = 0;
      n_fail  = 0;
      step_id = 0;
      a1 = 32'h04030201;
      w1 = 32'h01010101;
      aa = 32'h090705FF;   // lanes -1, 5, 7, 9
      wa = 32'h04030280;   // lanes -128, 2, 3, 4
      ab = 32'h281E140A;   // lanes 10, 20, 30, 40
      wb = 32'h08070605;
      ad = 32'hFF007F80;   // lanes -128, 127, 0, -1
      wd = 32'h04030201;

      // Tile 1: three identical beats, start pulses in STREAM/FLUSH, s_valid in CLEAR/FLUSH
      add(3'b100, '0, '0, F_IDLE, '0, '0);
      add(3'b010, a1, w1, F_CLR,  '0, '0);
      add(3'b110, a1, w1, F_STR,  '0, '0);
      add(3'b110, a1, w1, F_STAV, r4(rv(1), Z9, Z9, Z9), c4(1, Z8, Z8, Z8));
      add(3'b011, a1, w1, F_STAV, r4(rv(1), rv(2), Z9, Z9), c4(1, 1, Z8, Z8));
      add(3'b000, '0, '0, F_FLAV, r4(rv(1), rv(2), rv(3), Z9), c4(1, 1, 1, Z8));
      add(3'b100, '0, '0, F_FLAV, r4(Z9, rv(2), rv(3), rv(4)), c4(Z8, 1, 1, 1));
      add(3'b011, a1, w1, F_FLAV, r4(Z9, Z9, rv(3), rv(4)), c4(Z8, Z8, 1, 1));
      add(3'b000, '0, '0, F_FLAV, r4(Z9, Z9, Z9, rv(4)), c4(Z8, Z8, Z8, 1));
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_DONE, '0, '0);
      add(3'b000, '0, '0, F_IDLE, '0, '0);
      // Tile 2: s_valid 1,0,0,1 with hold during gaps
      add(3'b100, '0, '0, F_IDLE, '0, '0);
      add(3'b000, '0, '0, F_CLR,  '0, '0);
      add(3'b010, aa, wa, F_STR,  '0, '0);
      add(3'b000, 32'h11111111, 32'h22222222, F_STAV, r4(rv(-1), Z9, Z9, Z9),
          c4(8'h80, Z8, Z8, Z8));
      add(3'b000, 32'h33333333, 32'h44444444, F_STR, r4(rv(-1), Z9, Z9, Z9),
          c4(8'h80, Z8, Z8, Z8));
      add(3'b011, ab, wb, F_STR,  r4(rv(-1), Z9, Z9, Z9), c4(8'h80, Z8, Z8, Z8));
      add(3'b000, '0, '0, F_FLAV, r4(rv(10), rv(5), Z9, Z9), c4(5, 2, Z8, Z8));
      add(3'b000, '0, '0, F_FLAV, r4(Z9, rv(20), rv(7), Z9), c4(Z8, 6, 3, Z8));
      add(3'b000, '0, '0, F_FLAV, r4(Z9, Z9, rv(30), rv(9)), c4(Z8, Z8, 7, 4));
      add(3'b000, '0, '0, F_FLAV, r4(Z9, Z9, Z9, rv(40)), c4(Z8, Z8, Z8, 8));
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_DONE, '0, '0);
      add(3'b000, '0, '0, F_IDLE, '0, '0);
      // Tile 3: single-beat tile with extreme activations
      add(3'b100, '0, '0, F_IDLE, '0, '0);
      add(3'b000, '0, '0, F_CLR,  '0, '0);
      add(3'b011, ad, wd, F_STR,  '0, '0);
      add(3'b000, '0, '0, F_FLAV, r4(rv(-128), Z9, Z9, Z9), c4(1, Z8, Z8, Z8));
      add(3'b000, '0, '0, F_FLAV, r4(Z9, rv(127), Z9, Z9), c4(Z8, 2, Z8, Z8));
      add(3'b000, '0, '0, F_FLAV, r4(Z9, Z9, rv(0), Z9), c4(Z8, Z8, 3, Z8));
      add(3'b000, '0, '0, F_FLAV, r4(Z9, Z9, Z9, rv(-1)), c4(Z8, Z8, Z8, 4));
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_FLAV, '0, '0);
      add(3'b000, '0, '0, F_DONE, '0, '0);
      add(3'b000, '0, '0, F_IDLE, '0, '0);

      // Reset
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (2) @(negedge clk);
      chk("reset_ctrl", 64'(flags_now), 64'(F_IDLE));
      chk("reset_row", 64'(row_bus), 64'd0);
      chk("reset_col", 64'(col_bus), 64'd0);
      rst_n = 1'b1;

      foreach (vec_q[k]) begin
         @(negedge clk);
         step_id = k;
         drive(vec_q[k].ctl_in[2], vec_q[k].ctl_in[1], vec_q[k].ctl_in[0],
               vec_q[k].act, vec_q[k].wgt);
         chk("ctrl", 64'(flags_now), 64'(vec_q[k].flags));
         chk("row_bus", 64'(row_bus), 64'(vec_q[k].row));
         chk("col_bus", 64'(col_bus), 64'(vec_q[k].col));
      end

      // Reset during FLUSH aborts the tile
      step_id = 1000;
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk); drive(1'b0, 1'b1, 1'b1, a1, w1);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, '0, '0);
      chk("abort_in_flush", 64'(flags_now), 64'(F_FLAV));
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("abort_ctrl", 64'(flags_now), 64'(F_IDLE));
      chk("abort_row", 64'(row_bus), 64'd0);
      chk("abort_col", 64'(col_bus), 64'd0);
      saw_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);

      // Fresh tile after abort: two beats -> 2 + 2N-2 advances
      step_id = 2000;
      av_cnt   = 0;
      clr_cnt  = 0;
      saw_done = 1'b0;
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, '0, '0);
      clr_cnt += int'(arr_clear);
      @(negedge clk); drive(1'b0, 1'b1, 1'b0, a1, w1);
      @(negedge clk); drive(1'b0, 1'b1, 1'b1, a1, w1);
      av_cnt += int'(arr_valid);
      chk("post_lane0", 64'(row_bus[8:0]), 64'(rv(1)));
      for (int c = 0; c < 30 && !saw_done; c++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 1'b0, '0, '0);
         av_cnt  += int'(arr_valid);
         clr_cnt += int'(arr_clear);
         if (done) saw_done = 1'b1;
      end
      chk("post_done_seen", 64'(saw_done), 64'd1);
      chk("post_arr_valid_count", 64'(av_cnt), 64'(2 + 2 * N - 2));
      chk("post_clear_count", 64'(clr_cnt), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
